reg_pipe: RTL and testbench
===========================

REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (1..64).
REQ-002 Parameter DEPTH, default 4, number of register stages (1..16).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 RESET  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  synchronous pipeline clear.
REQ-006 in_valid  input  1  upstream word present.
REQ-007 in_ready  output  1  pipeline accepts upstream word this cycle.
REQ-008 in_data  input  WIDTH  upstream word.
REQ-009 out_valid  output  1  stage DEPTH-1 holds a valid word.
REQ-010 out_ready  input  1  downstream accepts word this cycle.
REQ-011 out_data  output  WIDTH  word held in stage DEPTH-1.
REQ-012 occupancy  output  clog2(DEPTH+1)  count of valid stages.

Function
REQ-013 Stages 0..DEPTH-1; each stage holds a WIDTH-bit data register and a valid bit v[i]; stage 0 is the input stage, stage DEPTH-1 drives out_data/out_valid directly (no combinational path from in_data to out_data).
REQ-014 Stage ready: r[DEPTH-1] = !v[DEPTH-1] | out_ready; r[i] = !v[i] | r[i+1] for i < DEPTH-1 (bubble collapsing).
REQ-015 in_ready = r[0] & !flush; transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
REQ-016 When r[i] is 1, stage i loads data and valid from stage i-1 (stage 0 from in_data, in_valid & in_ready); when r[i] is 0, stage i holds data and valid.
REQ-017 Data register of a stage loads only when its incoming valid is 1; stage data with v[i]=0 holds its old value.
REQ-018 Latency: a word accepted at edge N with no stall appears with out_valid=1 after edge N+DEPTH-1 (i.e. visible on out_data DEPTH-1 cycles after the accepting edge; DEPTH=1 gives visibility immediately after the accepting edge).
REQ-019 Throughput: one word per cycle sustained when out_ready stays 1.
REQ-020 Ordering: words exit in acceptance order; no word lost, duplicated or reordered under any in_valid/out_ready pattern.
REQ-021 Full: all v[i]=1 and out_ready=0 -> in_ready=0; simultaneous out transfer with full pipeline -> in_ready=1 same cycle (pass-through, no bubble).
REQ-022 Bubbles: an invalid stage is always filled from upstream on the next edge even when downstream is stalled.
REQ-023 occupancy = popcount of v[0..DEPTH-1], combinational from registered valid bits; range 0..DEPTH.
REQ-024 flush=1 at an edge clears every v[i] to 0; any out transfer in that cycle still counts as completed; no input is accepted (in_ready=0); data registers hold.
REQ-025 flush has priority over all loads; flush with out_ready=0 still clears.
REQ-026 out_valid and in_ready are free of glitches caused by in_data; in_ready depends only on v[], out_ready and flush.

Reset
REQ-027 RESET=1 clears all v[i] to 0 immediately, independent of clk.
REQ-028 RESET=1 clears all data registers to 0; out_data=0, out_valid=0, occupancy=0 while RESET is asserted and after release.
REQ-029 While RESET=1, in_ready=0; after deassertion, in_ready follows REQ-015 from the first edge.
REQ-030 RESET asserted mid-stream discards all in-flight words; no partial word emerges after release.

Verification
REQ-031 WIDTH=8, DEPTH=4; stream 0x01..0x08 back-to-back, out_ready=1 -> out_data 0x01..0x08 on 8 consecutive cycles, first valid 3 cycles after first accept edge.
REQ-032 Fill with 0xA0..0xA3, out_ready=0 -> occupancy=4, in_ready=0; raise out_ready with in_valid=1, in_data=0xA4 -> 0xA0 exits and 0xA4 accepted in same cycle, occupancy stays 4.
REQ-033 Load 0x11 only, out_ready=0 for 6 cycles -> 0x11 reaches stage 3 and holds, occupancy=1, in_ready=1 throughout.
REQ-034 Occupancy 3, assert flush for one cycle with in_valid=1 -> in_ready=0 that cycle, occupancy=0 next cycle, offered word not accepted.
REQ-035 Assert RESET asynchronously between edges with occupancy 4 -> out_valid=0, out_data=0, occupancy=0 before next edge; after release stream 0x55 -> emerges alone as expected.
REQ-036 Random in_valid/out_ready at 50% each, 10000 words, DEPTH in {1,4,16} -> scoreboard shows exact order, no loss or duplication.

Source files
------------

// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage valid/ready register pipeline with bubble collapsing,
// synchronous flush, asynchronous reset and a popcount occupancy output.
module reg_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         RESET,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] up_valid;
  logic [WIDTH-1:0] up_data [DEPTH];
  logic             accept;

  // A stage can take a word when it, or any stage downstream of it, has a
  // hole, or the sink is draining; the running OR avoids a self-referencing
  // vector chain.
  always_comb begin
    logic ready_acc;
    // NOTE: blocking assignments here, because later iterations must see the
    // value just computed within the same evaluation.
    ready_acc = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      ready_acc = ready_acc | ~valid_q[i];
      ready[i]  = ready_acc;
    end
  end

  assign in_ready = ready[0] & ~flush & ~RESET;
  assign accept   = in_valid & in_ready;

  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (here first, unconditionally), otherwise a latch is inferred.
    up_valid[0] = accept;
    up_data[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_valid[i] = valid_q[i-1];
      up_data[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      valid_q <= '0;
      // NOTE: the data registers are reset as well as the valid bits, so that
      // out_data reads zero during and right after reset.
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments for state, so every stage samples its
      // upstream neighbour's pre-edge value and words shift by exactly one.
      for (int i = 0; i < DEPTH; i++) begin
        if (flush) begin
          valid_q[i] <= 1'b0;
        end else if (ready[i]) begin
          valid_q[i] <= up_valid[i];
          if (up_valid[i]) begin
            data_q[i] <= up_data[i];
          end
        end
      end
    end
  end

  always_comb begin
    logic [OCC_W-1:0] count;
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + OCC_W'(valid_q[i]);
    end
    occupancy = count;
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: directed checks on a WIDTH=8/DEPTH=4 pipeline, then a random
// valid/ready stream of sequence numbers through DEPTH 1, 4 and 16 pipelines.
module tb_reg_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       RESET;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] occupancy;

  reg_pipe #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .RESET(RESET), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  logic        iv  [3];
  logic        ir  [3];
  logic        ov  [3];
  logic        ord [3];
  logic [15:0] id  [3];
  logic [15:0] od  [3];
  logic [0:0]  occ1;
  logic [2:0]  occ4;
  logic [4:0]  occ16;

  reg_pipe #(.WIDTH(16), .DEPTH(1)) dut_d1 (
    .clk(clk), .RESET(RESET), .flush(1'b0),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ord[0]), .out_data(od[0]),
    .occupancy(occ1)
  );
  reg_pipe #(.WIDTH(16), .DEPTH(4)) dut_d4 (
    .clk(clk), .RESET(RESET), .flush(1'b0),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ord[1]), .out_data(od[1]),
    .occupancy(occ4)
  );
  reg_pipe #(.WIDTH(16), .DEPTH(16)) dut_d16 (
    .clk(clk), .RESET(RESET), .flush(1'b0),
    .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_ready(ord[2]), .out_data(od[2]),
    .occupancy(occ16)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land on the falling edge, where outputs are stable.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam int N_WORDS   = 10000;
  localparam int MAX_CYCLE = 60000;

  int    acc_n [3];
  int    out_n [3];
  string nm    [3] = '{"d1", "d4", "d16"};

  initial begin
    RESET = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ord[k] = 1'b0; id[k] = 16'h0000; acc_n[k] = 0; out_n[k] = 0;
    end

    // Reset state, before any clock edge.
    #2;
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    @(negedge clk);
    RESET = 1'b0;
    #1 check("rel_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back stream 0x01..0x08 with the sink always ready.
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8);
      in_data  = 8'(c + 1);
      #1 check("stream_in_ready", 64'(in_ready), 64'd1);
      step();
      check("stream_out_valid", 64'(out_valid), 64'((c >= 3) && (c <= 10)));
      if ((c >= 3) && (c <= 10)) check("stream_out_data", 64'(out_data), 64'(c - 2));
    end
    in_valid = 1'b0;
    check("stream_occ_end", 64'(occupancy), 64'd0);

    // Fill to full while stalled, then pass-through on the release cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 8'(8'hA0 + k);
      #1 check("fill_in_ready", 64'(in_ready), 64'd1);
      step();
    end
    in_data = 8'hA4;
    #1;
    check("full_occupancy", 64'(occupancy), 64'd4);
    check("full_in_ready",  64'(in_ready),  64'd0);
    check("full_out_data",  64'(out_data),  64'hA0);
    check("full_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    #1 check("pass_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("pass_occupancy", 64'(occupancy), 64'd4);
    for (int k = 1; k <= 4; k++) begin
      check("drain_out_valid", 64'(out_valid), 64'd1);
      check("drain_out_data",  64'(out_data),  64'(8'hA0 + k));
      step();
    end
    check("drain_occ_end",   64'(occupancy), 64'd0);
    check("drain_valid_end", 64'(out_valid), 64'd0);

    // A single word travels to the last stage and parks while the sink stalls.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    step();
    in_valid = 1'b0;
    for (int j = 0; j <= 6; j++) begin
      check("single_occupancy", 64'(occupancy), 64'd1);
      check("single_in_ready",  64'(in_ready),  64'd1);
      check("single_out_valid", 64'(out_valid), 64'(j >= 3));
      step();
    end
    check("single_out_data", 64'(out_data), 64'h11);
    out_ready = 1'b1;
    step();
    check("single_drained", 64'(occupancy), 64'd0);

    // Flush with three words in flight and a word offered; last-stage data holds.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'(8'hB0 + k);
      step();
    end
    check("pre_flush_occ", 64'(occupancy), 64'd3);
    flush   = 1'b1;
    in_data = 8'hB3;
    #1 check("flush_in_ready", 64'(in_ready), 64'd0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_occupancy", 64'(occupancy), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_data_hold", 64'(out_data),  64'h11);
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step();
      check("flush_no_accept", 64'(out_valid), 64'd0);
    end

    // Asynchronous reset between edges with a full pipeline.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 8'(8'hC0 + k);
      step();
    end
    in_valid = 1'b0;
    check("pre_reset_occ", 64'(occupancy), 64'd4);
    #2 RESET = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_data",  64'(out_data),  64'd0);
    check("arst_occupancy", 64'(occupancy), 64'd0);
    check("arst_in_ready",  64'(in_ready),  64'd0);
    @(negedge clk);
    RESET = 1'b0;
    #1 check("arst_rel_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    step();
    in_valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      check("post_rst_valid", 64'(out_valid), 64'(j == 3));
      check("post_rst_occ",   64'(occupancy), 64'(j <= 3));
      if (j == 3) check("post_rst_data", 64'(out_data), 64'h55);
      step();
    end

    // Random valid/ready; each pipeline carries consecutive sequence numbers.
    for (int cyc = 0; cyc < MAX_CYCLE; cyc++) begin
      for (int k = 0; k < 3; k++) begin
        iv[k]  = (acc_n[k] < N_WORDS) ? 1'($urandom_range(1)) : 1'b0;
        id[k]  = 16'(acc_n[k]);
        ord[k] = 1'($urandom_range(1));
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        if (ov[k] && ord[k]) begin
          check({"rand_", nm[k], "_order"},  64'(od[k]), 64'(out_n[k]));
          check({"rand_", nm[k], "_exists"}, 64'(out_n[k] < acc_n[k]), 64'd1);
          out_n[k]++;
        end
        if (iv[k] && ir[k]) acc_n[k]++;
      end
      if (out_n[0] == N_WORDS && out_n[1] == N_WORDS && out_n[2] == N_WORDS) break;
      step();
    end
    for (int k = 0; k < 3; k++) begin
      iv[k]  = 1'b0;
      ord[k] = 1'b1;
      check({"rand_", nm[k], "_out_count"}, 64'(out_n[k]), 64'(N_WORDS));
      check({"rand_", nm[k], "_in_count"},  64'(acc_n[k]), 64'(N_WORDS));
    end
    step();
    check("rand_d1_occ_end",  64'(occ1),  64'd0);
    check("rand_d4_occ_end",  64'(occ4),  64'd0);
    check("rand_d16_occ_end", 64'(occ16), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
